// File: rtl/universal_shift_reg_param.sv
// universal_shift_reg_param
//   Parametrised universal shift register with a frame counter. Bridges
//   serial links and parallel datapath registers: it can load a whole word,
//   shift or rotate in either direction, or shift right arithmetically.
//   Every WIDTH shifts it marks a word boundary with frame_done, so a
//   serial-in/parallel-out or parallel-in/serial-out transfer can be framed.
//
// Parameters
//   WIDTH      register width in bits (must be >= 2)
//   RESET_VAL  register contents after reset
//   CW         frame-counter width, derived from WIDTH
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous reset, ACTIVE-HIGH despite the name; wins over en/mode
//   en            clock enable; 0 freezes q and bit_cnt, frame_done drops
//   mode          operation select (see mode_e below)
//   p_din         parallel load data
//   s_left_din    serial input entering at the MSB on right shifts
//   s_right_din   serial input entering at the LSB on left shifts
//   p_dout        register contents q
//   s_left_dout   q[WIDTH-1], serial output for left shifts
//   s_right_dout  q[0], serial output for right shifts
//   bit_cnt       shifts since the last load/reset, 0..WIDTH-1
//   frame_done    one-cycle pulse at the edge that completes WIDTH shifts
//
// There is no handshake: every enabled edge performs exactly one operation.
// All outputs are registers or bits of q, so nothing is combinational from
// the inputs.
module universal_shift_reg_param #(
  parameter int                    WIDTH     = 16,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0,
  localparam int                   CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] p_din,
  input  logic             s_left_din,
  input  logic             s_right_din,
  output logic [WIDTH-1:0] p_dout,
  output logic             s_left_dout,
  output logic             s_right_dout,
  output logic [CW-1:0]    bit_cnt,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  mode_e            mode_op;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             is_shift;
  logic             is_load;

  assign mode_op = mode_e'(mode);

  // Next register value for the selected operation; HOLD and RSVD keep q.
  always_comb begin
    q_next   = q;
    is_shift = 1'b0;
    is_load  = 1'b0;
    case (mode_op)
      MODE_LOAD: begin
        q_next  = p_din;
        is_load = 1'b1;
      end
      MODE_SHL: begin
        q_next   = {q[WIDTH-2:0], s_right_din};
        is_shift = 1'b1;
      end
      MODE_SHR: begin
        q_next   = {s_left_din, q[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_ROL: begin
        q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
        is_shift = 1'b1;
      end
      MODE_ROR: begin
        q_next   = {q[0], q[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_ASR: begin
        q_next   = {q[WIDTH-1], q[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      default: begin
        q_next = q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      q          <= RESET_VAL;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else if (en) begin
      q <= q_next;
      if (is_load) begin
        bit_cnt    <= '0;
        frame_done <= 1'b0;
      end else if (is_shift) begin
        // The WIDTH-th shift of a frame wraps the count and flags the
        // boundary in the same edge that q takes its final shifted value.
        if (bit_cnt == LAST_CNT) begin
          bit_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          bit_cnt    <= bit_cnt + 1'b1;
          frame_done <= 1'b0;
        end
      end else begin
        frame_done <= 1'b0;
      end
    end else begin
      frame_done <= 1'b0;
    end
  end

  assign p_dout       = q;
  assign s_left_dout  = q[WIDTH-1];
  assign s_right_dout = q[0];

endmodule

// File: tb/tb_universal_shift_reg_param.sv
// Bench for universal_shift_reg_param at WIDTH=8, RESET_VAL=8'hA5.
// The reference model keeps the register as an integer and uses plain
// arithmetic (multiply/divide by two, modulo 256) plus a running shift count
// since the last load/reset; frame boundaries are count % 8 == 0.
module tb_universal_shift_reg_param;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] RV = 8'hA5;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  p_din;
  logic          s_left_din;
  logic          s_right_din;
  logic [W-1:0]  p_dout;
  logic          s_left_dout;
  logic          s_right_dout;
  logic [CW-1:0] bit_cnt;
  logic          frame_done;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_q;
  int m_shifts;
  bit m_fd;

  universal_shift_reg_param #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .p_din       (p_din),
    .s_left_din  (s_left_din),
    .s_right_din (s_right_din),
    .p_dout      (p_dout),
    .s_left_dout (s_left_dout),
    .s_right_dout(s_right_dout),
    .bit_cnt     (bit_cnt),
    .frame_done  (frame_done)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: applies one cycle of inputs, advances the model, waits for the
  // edge and returns 1 time unit after it so outputs are settled.
  task automatic step(input bit r, input bit e, input logic [2:0] m,
                      input logic [W-1:0] d, input bit sl, input bit sr);
    int bit_in;
    rst_n = r; en = e; mode = m; p_din = d; s_left_din = sl; s_right_din = sr;
    if (r) begin
      m_q = int'(RV); m_shifts = 0; m_fd = 0;
    end else if (!e) begin
      m_fd = 0;
    end else if (m == 3'd1) begin
      m_q = int'(d); m_shifts = 0; m_fd = 0;
    end else if (m >= 3'd2 && m <= 3'd6) begin
      case (m)
        3'd2: m_q = (m_q * 2) % 256 + int'(sr);
        3'd3: m_q = m_q / 2 + 128 * int'(sl);
        3'd4: m_q = (m_q * 2) % 256 + m_q / 128;
        3'd5: m_q = m_q / 2 + 128 * (m_q % 2);
        default: begin
          bit_in = (m_q >= 128) ? 1 : 0;
          m_q = m_q / 2 + 128 * bit_in;
        end
      endcase
      m_shifts = m_shifts + 1;
      m_fd = (m_shifts % W == 0);
    end else begin
      m_fd = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 3'd0, 8'h00, 0, 0);
    checks++;
    if (p_dout !== 8'hA5) begin errors++; $display("FAIL reset_q: got %h want a5", p_dout); end
    checks++;
    if (bit_cnt !== 0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bit_cnt); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    step(1, 1, 3'd1, 8'hFF, 0, 0);
    checks++;
    if (p_dout !== 8'hA5) begin errors++; $display("FAIL reset_priority: got %h want a5", p_dout); end
  endtask

  task automatic test_sipo();
    bit pat [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    step(0, 1, 3'd1, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 3'd2, 8'(($urandom_range(0, 255))), 1'($urandom_range(0, 1)), pat[i]);
      checks++;
      if (frame_done !== (i == 7)) begin
        errors++; $display("FAIL sipo_fd[%0d]: got %b want %b", i, frame_done, (i == 7));
      end
    end
    checks++;
    if (p_dout !== 8'hB2) begin errors++; $display("FAIL sipo_q: got %h want b2", p_dout); end
    checks++;
    if (bit_cnt !== 0) begin errors++; $display("FAIL sipo_cnt: got %0d want 0", bit_cnt); end
    checks++;
    if (s_left_dout !== 1'b1) begin errors++; $display("FAIL sipo_sl_out: got %b want 1", s_left_dout); end
    step(0, 1, 3'd0, 8'h00, 0, 0);
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL sipo_fd_pulse: got %b want 0", frame_done); end
  endtask

  task automatic test_piso();
    bit exp_bits [8] = '{1, 1, 0, 0, 0, 0, 1, 1};
    step(0, 1, 3'd1, 8'hC3, 0, 0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (s_right_dout !== exp_bits[i]) begin
        errors++; $display("FAIL piso_sr_out[%0d]: got %b want %b", i, s_right_dout, exp_bits[i]);
      end
      step(0, 1, 3'd3, 8'h00, 0, 1'($urandom_range(0, 1)));
    end
    checks++;
    if (p_dout !== 8'h00) begin errors++; $display("FAIL piso_q: got %h want 00", p_dout); end
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL piso_fd: got %b want 1", frame_done); end
  endtask

  task automatic test_rotate_asr();
    step(0, 1, 3'd1, 8'h81, 0, 0);
    step(0, 1, 3'd4, 8'h00, 0, 0);
    checks++;
    if (p_dout !== 8'h03) begin errors++; $display("FAIL rol: got %h want 03", p_dout); end
    step(0, 1, 3'd1, 8'h81, 0, 0);
    step(0, 1, 3'd5, 8'h00, 0, 0);
    checks++;
    if (p_dout !== 8'hC0) begin errors++; $display("FAIL ror: got %h want c0", p_dout); end
    step(0, 1, 3'd1, 8'h90, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'd6, 8'h00, 0, 1);
    checks++;
    if (p_dout !== 8'hF2) begin errors++; $display("FAIL asr_neg: got %h want f2", p_dout); end
    step(0, 1, 3'd1, 8'h70, 0, 0);
    step(0, 1, 3'd6, 8'h00, 1, 1);
    checks++;
    if (p_dout !== 8'h38) begin errors++; $display("FAIL asr_pos: got %h want 38", p_dout); end
  endtask

  task automatic test_enable_hold();
    logic [W-1:0] frozen_q;
    step(0, 1, 3'd1, 8'(($urandom_range(0, 255))), 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 1, 3'd2, 8'h00, 0, 1'($urandom_range(0, 1)));
    checks++;
    if (bit_cnt !== 5) begin errors++; $display("FAIL hold_cnt_start: got %0d want 5", bit_cnt); end
    frozen_q = 8'(m_q);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 3'($urandom_range(1, 6)), 8'(($urandom_range(0, 255))), 1, 1);
      checks++;
      if (p_dout !== frozen_q || bit_cnt !== 5 || frame_done !== 1'b0) begin
        errors++; $display("FAIL en_low[%0d]: got q=%h cnt=%0d fd=%b want q=%h cnt=5 fd=0",
                           i, p_dout, bit_cnt, frame_done, frozen_q);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 3'd7, 8'(($urandom_range(0, 255))), 1, 1);
      checks++;
      if (p_dout !== frozen_q || bit_cnt !== 5 || frame_done !== 1'b0) begin
        errors++; $display("FAIL rsvd_hold[%0d]: got q=%h cnt=%0d fd=%b want q=%h cnt=5 fd=0",
                           i, p_dout, bit_cnt, frame_done, frozen_q);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 3'd3, 8'h00, 1'($urandom_range(0, 1)), 0);
      checks++;
      if (frame_done !== (i == 2)) begin
        errors++; $display("FAIL resume_fd[%0d]: got %b want %b", i, frame_done, (i == 2));
      end
    end
  endtask

  task automatic test_reset_mid();
    step(0, 1, 3'd1, 8'h3C, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 3'd4, 8'h00, 0, 0);
    step(1, 1, 3'd2, 8'h00, 0, 0);
    checks++;
    if (bit_cnt !== 0 || p_dout !== 8'hA5) begin
      errors++; $display("FAIL mid_reset: got cnt=%0d q=%h want cnt=0 q=a5", bit_cnt, p_dout);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 3'd2, 8'h00, 0, 1'($urandom_range(0, 1)));
      checks++;
      if (frame_done !== (i == 7)) begin
        errors++; $display("FAIL mid_reset_fd[%0d]: got %b want %b", i, frame_done, (i == 7));
      end
    end
  endtask

  task automatic test_back_to_back();
    step(0, 1, 3'd1, 8'h5A, 0, 0);
    for (int i = 0; i < 24; i++) begin
      // mixed directions still count toward the frame
      step(0, 1, 3'($urandom_range(2, 6)), 8'h00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++;
      if (frame_done !== ((i % 8) == 7) || p_dout !== 8'(m_q)) begin
        errors++; $display("FAIL b2b[%0d]: got fd=%b q=%h want fd=%b q=%h",
                           i, frame_done, p_dout, ((i % 8) == 7), 8'(m_q));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)),
           8'(($urandom_range(0, 255))), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++;
      if (p_dout !== 8'(m_q) || bit_cnt !== CW'(m_shifts % W) || frame_done !== m_fd ||
          s_left_dout !== 1'(m_q / 128) || s_right_dout !== 1'(m_q % 2)) begin
        errors++;
        $display("FAIL random[%0d]: got q=%h cnt=%0d fd=%b sl=%b sr=%b want q=%h cnt=%0d fd=%b",
                 i, p_dout, bit_cnt, frame_done, s_left_dout, s_right_dout,
                 8'(m_q), m_shifts % W, m_fd);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; mode = 3'd0; p_din = '0;
    s_left_din = 1'b0; s_right_din = 1'b0;
    m_q = int'(RV); m_shifts = 0; m_fd = 0;
    @(negedge clk);
    test_reset();
    test_sipo();
    test_piso();
    test_rotate_asr();
    test_enable_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
